// File: rtl/muller_c_array_if.sv
// Signal bundle for the Muller C-element bank. The DUT uses the slave modport and
// the environment uses the master modport.
interface muller_c_array_if #(
  parameter int unsigned N     = 6,
  parameter int unsigned CH    = 4,
  parameter int unsigned CNT_W = 8
);
  logic [CH*N-1:0]     io_in;
  logic [N-1:0]        plus_mask;
  logic [N-1:0]        minus_mask;
  logic                cnt_clr;
  logic [CH-1:0]       io_out;
  logic [CH-1:0]       out_prev;
  logic [CH-1:0]       rise_pulse;
  logic [CH-1:0]       fall_pulse;
  logic [CH*CNT_W-1:0] trans_cnt;

  modport master (
    output io_in,
    output plus_mask,
    output minus_mask,
    output cnt_clr,
    input  io_out,
    input  out_prev,
    input  rise_pulse,
    input  fall_pulse,
    input  trans_cnt
  );

  modport slave (
    input  io_in,
    input  plus_mask,
    input  minus_mask,
    input  cnt_clr,
    output io_out,
    output out_prev,
    output rise_pulse,
    output fall_pulse,
    output trans_cnt
  );
endinterface

// File: rtl/muller_c_array.sv
// Clocked bank of CH generalised (optionally asymmetric) Muller C-elements with input
// synchronisers, registered edge pulses and saturating per-channel transition counters.
module muller_c_array #(
  parameter int unsigned N           = 6,
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter logic        RESET_VAL   = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  muller_c_array_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CH*N-1:0]  sync_q [SYNC_STAGES];
  logic [CH*N-1:0]  sync_d [SYNC_STAGES];
  logic [CH*N-1:0]  s;

  logic [N-1:0]     set_en;
  logic [N-1:0]     rst_en;
  logic             set_any;
  logic             rst_any;
  logic [CH-1:0]    set_ok;
  logic [CH-1:0]    rst_ok;

  logic [CH-1:0]    state_q;
  logic [CH-1:0]    state_d;
  logic [CH-1:0]    prev_q;
  logic [CH-1:0]    prev_d;
  logic [CH-1:0]    toggle;

  logic [CNT_W-1:0] cnt_q [CH];
  logic [CNT_W-1:0] cnt_d [CH];

  // Synchroniser chain; only the last stage is ever evaluated.
  always_comb begin
    sync_d[0] = bus.io_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A masked-out input is forced to the passing value; an all-masked condition never fires.
  assign set_en  = ~bus.minus_mask;
  assign rst_en  = ~bus.plus_mask;
  assign set_any = |set_en;
  assign rst_any = |rst_en;

  always_comb begin
    set_ok = '0;
    rst_ok = '0;
    for (int c = 0; c < CH; c++) begin
      set_ok[c] = set_any & (&(s[c*N +: N] | bus.minus_mask));
      rst_ok[c] = rst_any & ~(|(s[c*N +: N] & rst_en));
    end
  end

  always_comb begin
    state_d = state_q;
    for (int c = 0; c < CH; c++) begin
      if (state_q[c]) begin
        if (rst_ok[c]) begin
          state_d[c] = 1'b0;
        end
      end else if (set_ok[c]) begin
        state_d[c] = 1'b1;
      end
    end
  end

  assign prev_d = state_q;
  assign toggle = state_d ^ state_q;

  // Clear has priority over a coincident increment.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      cnt_d[c] = cnt_q[c];
      if (bus.cnt_clr) begin
        cnt_d[c] = '0;
      end else if (toggle[c] && (cnt_q[c] != CntMax)) begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= {CH{RESET_VAL}};
      prev_q  <= {CH{RESET_VAL}};
      for (int c = 0; c < CH; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      for (int c = 0; c < CH; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign bus.io_out     = state_q;
  assign bus.out_prev   = prev_q;
  assign bus.rise_pulse = state_q & ~prev_q;
  assign bus.fall_pulse = ~state_q & prev_q;

  always_comb begin
    bus.trans_cnt = '0;
    for (int c = 0; c < CH; c++) begin
      bus.trans_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
    end
  end

endmodule

// File: doc/muller_c_array.md
# muller_c_array

Clocked, multi-channel generalised Muller C-element bank for the asynchronous-primitives user project. Each of CH channels combines N inputs into a hysteretic output. Per-input masks make a channel an asymmetric C-element: some inputs gate only the rising transition, some only the falling one. Inputs are synchronised before use, and each channel reports edge pulses and a saturating transition count, so the bank can drive synchronous monitoring logic and the Caravel logic analyser directly.

## Interface
- N, 6, inputs per channel (≥2)
- CH, 4, number of independent channels (≥1)
- SYNC_STAGES, 2, synchroniser depth on io_in (≥1)
- CNT_W, 8, width of each per-channel transition counter (≥2)
- RESET_VAL, 1'b0, value loaded into every channel state on reset

- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- io_in  input  CH*N  channel inputs; channel c uses bits [c*N +: N]; asynchronous to clk
- plus_mask  input  N  bit i = 1: input i ignored by the falling (reset) condition, so it acts only on the rising edge; shared by all channels
- minus_mask  input  N  bit i = 1: input i ignored by the rising (set) condition; shared by all channels
- cnt_clr  input  1  synchronous clear of all counters
- io_out  output  CH  registered channel state
- out_prev  output  CH  io_out value of the previous cycle
- rise_pulse  output  CH  one-cycle high when io_out went 0→1 on the last edge
- fall_pulse  output  CH  one-cycle high when io_out went 1→0 on the last edge
- trans_cnt  output  CH*CNT_W  per-channel transition count; channel c at [c*CNT_W +: CNT_W]

## Operation
- Sync stage: io_in passes through a SYNC_STAGES flop chain. The result is s. Evaluation uses only s; raw io_in is never used.
- Per channel c with inputs x = s[c*N +: N]:
  - set_ok = every x[i] with minus_mask[i]=0 is 1, and at least one such i exists.
  - rst_ok = every x[i] with plus_mask[i]=0 is 0, and at least one such i exists.
  - A bit set in both masks is excluded from both conditions.
  - If all bits are excluded from a condition, that condition is false and the channel can never make that transition.
- State update per channel:
  - state=0 and set_ok: next state = 1.
  - state=1 and rst_ok: next state = 0.
  - Otherwise hold.
  - Only the condition matching the current state is evaluated, so there is no conflict when set_ok and rst_ok are both true.
- With masks all-zero, the channel is a classic symmetric C-element: it goes to 1 when all inputs are 1, goes to 0 when all inputs are 0, and holds otherwise.
- out_prev: registered copy of io_out, updated every cycle.
- Edge pulses:
  - rise_pulse = io_out & ~out_prev
  - fall_pulse = ~io_out & out_prev
  - Both are derived from registers, with no combinational path from inputs.
- trans_cnt:
  - Increments by 1 on every edge at which io_out changes.
  - Saturates at 2^CNT_W−1 and never wraps.
  - cnt_clr=1 forces all counters to 0 at the next edge. Clear wins over a coincident increment, and that transition is not counted.
- Masks are quasi-static. They are sampled combinationally in evaluation, so a change takes effect at the next evaluating edge. A mask change alone never forces a transition; it only changes which inputs are examined.

## Timing
- Reset values (asynchronous assert, any time):
  - Synchroniser flops = 0.
  - io_out = RESET_VAL; out_prev = RESET_VAL.
  - rise_pulse = 0; fall_pulse = 0; trans_cnt = 0.
- Deassertion of rst_n is taken as synchronous to clk. The first evaluation happens on the first rising edge with rst_n=1.
- Reset mid-operation: in-flight synchroniser contents are discarded. No pulse or count is produced by the reset itself.
- Latency: an io_in change stable for ≥1 cycle reaches io_out SYNC_STAGES+1 edges later. The pulse appears on the same edge as io_out. trans_cnt reflects the change on that same edge.
- Pulses:
  - Last exactly one cycle.
  - A channel cannot produce pulses on consecutive cycles unless the inputs satisfy opposite conditions on consecutive synchronised samples. In that case rise and fall alternate, and each is counted.
- Input glitches shorter than one clock period may be missed. This is intended: the bank samples inputs, it does not latch them.

## Test plan
- Reset: rst_n=0 with arbitrary io_in → io_out=RESET_VAL, out_prev=RESET_VAL, pulses 0, trans_cnt 0. Release, hold io_in=0 → no change.
- Symmetric, N=6, SYNC_STAGES=2: channel 0 inputs 0x00→0x3F → io_out[0]=1 and rise_pulse[0] for one cycle, 3 edges after the input edge. Then 0x15 → hold at 1. Then 0x00 → fall_pulse, trans_cnt[0]=2.
- Asymmetric: plus_mask=6'b000001, inputs 0x3F→0x01 → io_out falls (input 0 ignored for reset). minus_mask=6'b000010, inputs 0x3D → io_out rises (input 1 ignored for set).
- Fully masked: plus_mask=minus_mask=6'h3F, inputs toggled 0x00↔0x3F → io_out never changes, trans_cnt stays 0.
- Counter: CNT_W=2, 5 transitions → trans_cnt=3 (saturated). Assert cnt_clr on the same edge as a 6th transition → trans_cnt=0, and rise/fall_pulse still fires.
- Channel independence and mid-run reset: drive channels 0–3 with distinct patterns and check per-channel results. Pulse rst_n low between clock edges while a transition is in the synchroniser → all outputs return to reset values immediately, with no pulse after release.
